fwd_mux: RTL

Parametrised operand-forwarding multiplexer for the MIPS pipeline. It generalises the fixed three-way operand select into a `DEPTH`-entry history of in-flight register writes. It returns the youngest matching in-flight value for a source register, and otherwise the register-file value. It tracks pending load results and raises `stall` when the youngest match is not yet available. One instance sits in front of each ALU operand in decode/execute.

---
 rtl/fwd_mux_if.sv | 37 +++
 rtl/fwd_mux.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fwd_mux_if.sv
// Operand-forwarding bus: history write/fill controls in, selected operand out.
// master drives the pipeline side, slave is the forwarding mux.
interface fwd_mux_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int AW    = 5
);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             advance;
  logic             flush;
  logic             wr_en;
  logic             wr_pend;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             fill_en;
  logic [SW-1:0]    fill_slot;
  logic [WIDTH-1:0] fill_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rf_data;
  logic [WIDTH-1:0] out;
  logic             hit;
  logic [SW-1:0]    hit_slot;
  logic             stall;

  modport master (
    output advance, flush, wr_en, wr_pend, wr_addr, wr_data,
    output fill_en, fill_slot, fill_data, rd_addr, rf_data,
    input  out, hit, hit_slot, stall
  );

  modport slave (
    input  advance, flush, wr_en, wr_pend, wr_addr, wr_data,
    input  fill_en, fill_slot, fill_data, rd_addr, rf_data,
    output out, hit, hit_slot, stall
  );
endinterface

// File: rtl/fwd_mux.sv
// DEPTH-slot in-flight write history with youngest-first operand forwarding and load stall.
// Select is combinational; FWD_MUX_OUT_REG_EN registers the outputs for 1-cycle latency.
module fwd_mux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int AW    = 5
) (
  input  logic      clk,
  input  logic      rst,
  fwd_mux_if.slave  fwd
);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = SW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] pend_q,  pend_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [TW-1:0]    fill_tgt;

  // A fill racing an advance follows its entry to the next-older slot.
  assign fill_tgt = {1'b0, fwd.fill_slot} + (fwd.advance ? TW'(1) : TW'(0));

  always_comb begin
    valid_d = valid_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fwd.flush) begin
      valid_d = '0;
      pend_d  = '0;
    end else begin
      if (fwd.advance) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          valid_d[i] = valid_q[i-1];
          pend_d[i]  = pend_q[i-1];
          addr_d[i]  = addr_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        valid_d[0] = fwd.wr_en && (fwd.wr_addr != '0);
        pend_d[0]  = fwd.wr_en && fwd.wr_pend;
        addr_d[0]  = fwd.wr_addr;
        data_d[0]  = fwd.wr_data;
      end
      if (fwd.fill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fill_tgt == TW'(i) && valid_d[i] && pend_d[i]) begin
            pend_d[i] = 1'b0;
            data_d[i] = fwd.fill_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  logic [WIDTH-1:0] out_d;
  logic             hit_d;
  logic [SW-1:0]    hit_slot_d;
  logic             stall_d;

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    out_d      = fwd.rf_data;
    hit_d      = 1'b0;
    hit_slot_d = '0;
    stall_d    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == fwd.rd_addr) && (fwd.rd_addr != '0)) begin
        out_d      = data_q[i];
        hit_d      = 1'b1;
        hit_slot_d = SW'(i);
        stall_d    = pend_q[i];
      end
    end
  end

`ifdef FWD_MUX_OUT_REG_EN
  logic [WIDTH-1:0] out_q;
  logic             hit_q;
  logic [SW-1:0]    hit_slot_q;
  logic             stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      hit_q      <= 1'b0;
      hit_slot_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      out_q      <= out_d;
      hit_q      <= hit_d;
      hit_slot_q <= hit_slot_d;
      stall_q    <= stall_d;
    end
  end

  assign fwd.out      = out_q;
  assign fwd.hit      = hit_q;
  assign fwd.hit_slot = hit_slot_q;
  assign fwd.stall    = stall_q;
`else
  assign fwd.out      = out_d;
  assign fwd.hit      = hit_d;
  assign fwd.hit_slot = hit_slot_d;
  assign fwd.stall    = stall_d;
`endif
endmodule
